regfile_port_ctrl: RTL

REGFILE_PORT_CTRL -- requirements
Module: regfile_port_ctrl

---
 rtl/regfile_port_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/regfile_port_ctrl.sv
// Register-file port controller: queues writebacks and paces each one through a
// setup/strobe/hold write cycle, while serving reads with forwarding from the queue.
module regfile_port_ctrl #(
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        rd_valid,
  input  logic [4:0]  rd_reg1,
  input  logic [4:0]  rd_reg2,
  output logic        rd_done,
  output logic [31:0] rd_data1,
  output logic [31:0] rd_data2,
  output logic [4:0]  Reg1,
  output logic [4:0]  Reg2,
  output logic        OE,
  input  logic [31:0] Reg1_data,
  input  logic [31:0] Reg2_data,
  output logic [4:0]  Write_Reg,
  output logic [31:0] Write_Data,
  output logic        WS
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state;
  logic [4:0]    q_reg  [QDEPTH];
  logic [31:0]   q_data [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_nxt;
  logic [CW-1:0] count;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   fwd1;
  logic [31:0]   fwd2;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready looks only at the registered count, so a pop never frees a slot in its own cycle.
  assign wb_ready = (count < CW'(QDEPTH));
  assign accept   = wb_valid && wb_ready;
  assign push     = accept && (wb_reg != 5'd0);
  assign pop      = (state == HOLD);
  assign head_nxt = inc_ptr(head);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_reg[i]  <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (push) begin
        q_reg[tail]  <= wb_reg;
        q_data[tail] <= wb_data;
        tail         <= inc_ptr(tail);
      end
      if (pop) begin
        head <= head_nxt;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The head stays in the queue until HOLD ends, so reads keep seeing it while in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      WS         <= 1'b0;
      Write_Reg  <= '0;
      Write_Data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state      <= SETUP;
            Write_Reg  <= q_reg[head];
            Write_Data <= q_data[head];
          end
        end
        SETUP: begin
          state <= STROBE;
          WS    <= 1'b1;
        end
        STROBE: begin
          state <= HOLD;
          WS    <= 1'b0;
        end
        HOLD: begin
          if (count > CW'(1)) begin
            state      <= SETUP;
            Write_Reg  <= q_reg[head_nxt];
            Write_Data <= q_data[head_nxt];
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          WS    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Reg1    <= '0;
      Reg2    <= '0;
      OE      <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      OE      <= rd_valid;
      rd_done <= rd_valid;
      if (rd_valid) begin
        Reg1 <= rd_reg1;
        Reg2 <= rd_reg2;
      end
    end
  end

  // Walk the queue oldest to newest so the newest match wins; a write accepted now beats all.
  always_comb begin
    fwd1 = Reg1_data;
    fwd2 = Reg2_data;
    for (int i = 0; i < QDEPTH; i++) begin
      int slot;
      slot = int'(head) + i;
      if (slot >= QDEPTH) slot = slot - QDEPTH;
      if (i < int'(count)) begin
        if (q_reg[slot[PW-1:0]] == Reg1) fwd1 = q_data[slot[PW-1:0]];
        if (q_reg[slot[PW-1:0]] == Reg2) fwd2 = q_data[slot[PW-1:0]];
      end
    end
    if (accept && (wb_reg == Reg1)) fwd1 = wb_data;
    if (accept && (wb_reg == Reg2)) fwd2 = wb_data;
    if (Reg1 == 5'd0) fwd1 = '0;
    if (Reg2 == 5'd0) fwd2 = '0;
  end

  assign rd_data1 = rd_done ? fwd1 : '0;
  assign rd_data2 = rd_done ? fwd2 : '0;

endmodule
